store_rmw_ctrl: RTL and testbench
=================================

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

Interface
REQ-001 Parameter: D_WIDTH, 32, data word width; only 32 is supported.
REQ-002 Parameter: A_WIDTH, 32, byte address width.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset: clk input 1 (rising edge) and rst input 1 (synchronous, active-high).
REQ-004 req_valid  input  1  access request present.
REQ-005 req_ready  output  1  request accepted this cycle when high with req_valid.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 addrmode  input  3  000 byte, 001 half, 010 word, others word.
REQ-008 addr  input  A_WIDTH  byte address.
REQ-009 write_data  input  D_WIDTH  store data, low-aligned.
REQ-010 ram_addr  output  A_WIDTH  word-aligned RAM address {addr[A_WIDTH-1:2],2'b00}.
REQ-011 ram_we  output  1  RAM write enable.
REQ-012 ram_din  output  D_WIDTH  RAM write word.
REQ-013 ram_dout  input  D_WIDTH  RAM read word, valid one cycle after ram_addr is presented with ram_we=0.
REQ-014 rd_data / rd_valid  output  D_WIDTH / 1  raw aligned load word and its one-cycle qualifier; extension is handled downstream.
REQ-015 done / err  output  1 / 1  one-cycle access completion pulse and misalignment flag.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, MERGE, WRITE and ERR; req_ready SHALL equal (state==IDLE) and no other state accepts a request.
REQ-017 On acceptance the block SHALL register addr, addrmode, req_we and write_data; while a request is not accepted the requester holds its inputs.
REQ-018 Misalignment is defined as: half with addr[1:0]==11, or word (including unused modes) with addr[1:0]!=00.
REQ-019 After acceptance the next state SHALL be ERR if misaligned, else WRITE for a store word, else READ.
REQ-020 READ SHALL drive the registered aligned ram_addr with ram_we=0, then go to MERGE.
REQ-021 MERGE for a load SHALL drive rd_data=ram_dout, rd_valid=1 and done=1, then go to IDLE.
REQ-022 MERGE for a store SHALL register the merged word and go to WRITE.
REQ-023 Byte merge SHALL replace byte lane addr[1:0] with write_data[7:0] and keep the other lanes from ram_dout.
REQ-024 Half merge SHALL write write_data[15:0] into bits [15:0], [23:8] or [31:16] for offsets 0, 1 and 2 respectively.
REQ-025 WRITE SHALL assert ram_we=1 and done=1 for exactly one cycle, with ram_din equal to the merged word (byte/half) or write_data (word), then go to IDLE.
REQ-026 ERR SHALL assert err=1 and done=1 for one cycle with no RAM write, then go to IDLE.
REQ-027 Latency from the acceptance cycle T SHALL be: word store done at T+1, load done at T+2, byte/half store done at T+3, error done at T+1.
REQ-028 Outside the cycles defined above, ram_we, rd_valid, done and err SHALL be 0, and ram_din and rd_data SHALL be 0.
REQ-029 Back-to-back requests SHALL work: a new request can be accepted in the cycle after done.

Reset
REQ-030 While rst is high, state SHALL become IDLE at the next edge and all registered captures SHALL clear to 0.
REQ-031 ram_we SHALL be gated by !rst combinationally, so no RAM write occurs in any cycle with rst high, including reset asserted in WRITE.
REQ-032 Reset asserted mid-operation (READ or MERGE) SHALL abandon the access with no done, no rd_valid and no write.
REQ-033 After reset release, req_ready SHALL be 1 in the first cycle.

Verification
REQ-034 RAM word 0x11223344 at 0x100; sb addr 0x102, data 0xAB -> done at T+3, write 0x11AB3344 to 0x100.
REQ-035 RAM word 0x11223344 at 0x100; sh addr 0x101, data 0xBEEF -> write 0x11BEEF44 at T+3.
REQ-036 sw addr 0x104, data 0xCAFEF00D -> ram_we at T+1 with ram_din 0xCAFEF00D and no READ cycle; then load 0x104 -> rd_valid at T+2 with 0xCAFEF00D.
REQ-037 sh addr 0x103 -> err=done=1 at T+1 and ram_we never high; sw addr 0x102 -> same.
REQ-038 sb accepted, rst pulsed during MERGE -> no write, no done, req_ready=1 after release, RAM unchanged.
REQ-039 req_valid held high across two queued stores -> second accepted the cycle after the first done, both writes correct, req_ready=0 throughout the busy cycles.

Source files
------------

// File: rtl/store_rmw_ctrl.sv
// Load/store controller for a word-wide RAM. Sub-word stores are done as
// read-modify-write; misaligned accesses are rejected with an error pulse.
module store_rmw_ctrl #(
  parameter int D_WIDTH = 32,
  parameter int A_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [2:0]         addrmode,
  input  logic [A_WIDTH-1:0] addr,
  input  logic [D_WIDTH-1:0] write_data,
  output logic [A_WIDTH-1:0] ram_addr,
  output logic               ram_we,
  output logic [D_WIDTH-1:0] ram_din,
  input  logic [D_WIDTH-1:0] ram_dout,
  output logic [D_WIDTH-1:0] rd_data,
  output logic               rd_valid,
  output logic               done,
  output logic               err
);

  localparam int LANES = D_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, READ, MERGE, WRITE, ERR} state_t;

  state_t             state_reg, state_next;
  logic [A_WIDTH-1:0] addr_reg;
  logic [2:0]         mode_reg;
  logic               we_reg;
  logic [D_WIDTH-1:0] wdata_reg;
  logic [D_WIDTH-1:0] merged_reg;
  logic [D_WIDTH-1:0] merged_word;

  logic is_byte_in, is_half_in, misaligned_in;
  logic is_byte_reg, is_half_reg;
  logic [1:0] off_reg;

  assign is_byte_in    = (addrmode == 3'b000);
  assign is_half_in    = (addrmode == 3'b001);
  assign misaligned_in = is_byte_in ? 1'b0 :
                         is_half_in ? (addr[1:0] == 2'b11) :
                                      (addr[1:0] != 2'b00);

  assign is_byte_reg = (mode_reg == 3'b000);
  assign is_half_reg = (mode_reg == 3'b001);
  assign off_reg     = addr_reg[1:0];

  // Each lane takes the low store byte at the access offset, the second store
  // byte one lane above it for halfwords, or keeps the RAM byte otherwise.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic lo_sel, hi_sel;
      assign lo_sel = (off_reg == 2'(gi));
      if (gi == 0) begin : g_no_hi
        assign hi_sel = 1'b0;
      end else begin : g_hi
        assign hi_sel = is_half_reg && (off_reg == 2'(gi - 1));
      end
      assign merged_word[gi*8 +: 8] = lo_sel ? wdata_reg[7:0] :
                                      hi_sel ? wdata_reg[15:8] :
                                               ram_dout[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      addr_reg   <= '0;
      mode_reg   <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      merged_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        addr_reg  <= addr;
        mode_reg  <= addrmode;
        we_reg    <= req_we;
        wdata_reg <= write_data;
      end
      if (state_reg == MERGE) begin
        merged_reg <= merged_word;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (misaligned_in)                          state_next = ERR;
          else if (req_we && !is_byte_in && !is_half_in) state_next = WRITE;
          else                                        state_next = READ;
        end
      end
      READ:    state_next = MERGE;
      MERGE:   state_next = we_reg ? WRITE : IDLE;
      WRITE:   state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes and data are forced low while rst is high so a reset landing
  // mid-access can neither write the RAM nor report a completion.
  always_comb begin
    req_ready = (state_reg == IDLE);
    ram_addr  = {addr_reg[A_WIDTH-1:2], 2'b00};
    ram_we    = 1'b0;
    ram_din   = '0;
    rd_data   = '0;
    rd_valid  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    if (!rst) begin
      case (state_reg)
        MERGE: begin
          if (!we_reg) begin
            rd_data  = ram_dout;
            rd_valid = 1'b1;
            done     = 1'b1;
          end
        end
        WRITE: begin
          ram_we  = 1'b1;
          ram_din = (is_byte_reg || is_half_reg) ? merged_reg : wdata_reg;
          done    = 1'b1;
        end
        ERR: begin
          err  = 1'b1;
          done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Directed bench for store_rmw_ctrl: a vector table of single accesses against
// a small behavioural RAM, plus hand-written reset and back-to-back sequences.
module tb_store_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  addrmode;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_din;
  logic [31:0] ram_dout;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  store_rmw_ctrl #(.D_WIDTH(32), .A_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .addrmode(addrmode), .addr(addr), .write_data(write_data),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // RAM with registered read; preload port lets the bench seed words
  logic [31:0] mem [0:255];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr[9:2]] <= ram_din;
    else if (pre_en) mem[pre_idx] <= pre_val;
    ram_dout <= mem[ram_addr[9:2]];
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    pre_en  = 1'b1;
    pre_idx = a[9:2];
    pre_val = v;
    tick();
    pre_en  = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre;
    logic [31:0] init;
    int          lat;
    logic        e;
    logic [31:0] expw;
  } vec_t;

  vec_t vecs [16];

  task automatic run_vec(input int n, input vec_t v);
    int lat, nwr, nrd;
    logic got_err, got_done, ready_busy;
    logic [31:0] wa, wd, rdd;
    logic exp_wr, exp_rd;
    lat = 0; nwr = 0; nrd = 0;
    got_err = 1'b0; got_done = 1'b0; ready_busy = 1'b0;
    wa = '0; wd = '0; rdd = '0;
    if (v.pre) preload(v.addr, v.init);
    req_valid  = 1'b1;
    req_we     = v.we;
    addrmode   = v.mode;
    addr       = v.addr;
    write_data = v.wdata;
    chk($sformatf("v%0d_ready_idle", n), 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8 && !got_done; c++) begin
      if (c > 1) tick();
      if (ram_we) begin nwr++; wa = ram_addr; wd = ram_din; end
      if (rd_valid) begin nrd++; rdd = rd_data; end
      if (err) got_err = 1'b1;
      if (done) begin got_done = 1'b1; lat = c; end
      if (req_ready) ready_busy = 1'b1;
    end
    exp_wr = v.we && !v.e;
    exp_rd = !v.we && !v.e;
    chk($sformatf("v%0d_latency", n), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_err", n), 32'(got_err), 32'(v.e));
    chk($sformatf("v%0d_ready_busy", n), 32'(ready_busy), 32'd0);
    chk($sformatf("v%0d_nwrites", n), 32'(nwr), 32'(exp_wr));
    chk($sformatf("v%0d_nrdvalid", n), 32'(nrd), 32'(exp_rd));
    if (exp_wr) begin
      chk($sformatf("v%0d_waddr", n), wa, {v.addr[31:2], 2'b00});
      chk($sformatf("v%0d_wdata", n), wd, v.expw);
    end
    if (exp_rd) chk($sformatf("v%0d_rdata", n), rdd, v.expw);
    tick();
    chk($sformatf("v%0d_ready_after", n), 32'(req_ready), 32'd1);
    chk($sformatf("v%0d_idle_strobes", n), {28'd0, done, ram_we, rd_valid, err}, 32'd0);
    chk($sformatf("v%0d_idle_data", n), ram_din | rd_data, 32'd0);
    $display("vec %0d we=%0b mode=%b addr=%h wdata=%h lat=%0d err=%0b wr=%h rd=%h",
             n, v.we, v.mode, v.addr, v.wdata, lat, got_err, wd, rdd);
  endtask

  initial begin
    int q;
    vecs[0]  = '{1'b1, 3'b000, 32'h102, 32'h000000AB, 1'b1, 32'h11223344, 3, 1'b0, 32'h11AB3344};
    vecs[1]  = '{1'b1, 3'b001, 32'h101, 32'h0000BEEF, 1'b1, 32'h11223344, 3, 1'b0, 32'h11BEEF44};
    vecs[2]  = '{1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 1'b0, 32'h0,        1, 1'b0, 32'hCAFEF00D};
    vecs[3]  = '{1'b0, 3'b010, 32'h104, 32'h0,        1'b0, 32'h0,        2, 1'b0, 32'hCAFEF00D};
    vecs[4]  = '{1'b1, 3'b001, 32'h103, 32'h00001234, 1'b0, 32'h0,        1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 3'b010, 32'h102, 32'h12345678, 1'b0, 32'h0,        1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'b000, 32'h100, 32'h00000055, 1'b1, 32'hAABBCCDD, 3, 1'b0, 32'hAABBCC55};
    vecs[7]  = '{1'b1, 3'b000, 32'h103, 32'h00000066, 1'b1, 32'hAABBCCDD, 3, 1'b0, 32'h66BBCCDD};
    vecs[8]  = '{1'b1, 3'b001, 32'h102, 32'h00001234, 1'b1, 32'hAABBCCDD, 3, 1'b0, 32'h1234CCDD};
    vecs[9]  = '{1'b1, 3'b001, 32'h100, 32'h00005678, 1'b1, 32'hAABBCCDD, 3, 1'b0, 32'hAABB5678};
    vecs[10] = '{1'b1, 3'b111, 32'h108, 32'h0BADBEEF, 1'b0, 32'h0,        1, 1'b0, 32'h0BADBEEF};
    vecs[11] = '{1'b1, 3'b101, 32'h109, 32'h00000001, 1'b0, 32'h0,        1, 1'b1, 32'h0};
    vecs[12] = '{1'b0, 3'b000, 32'h10D, 32'h0,        1'b1, 32'h01020304, 2, 1'b0, 32'h01020304};
    vecs[13] = '{1'b0, 3'b010, 32'h10E, 32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0};
    vecs[14] = '{1'b1, 3'b000, 32'h110, 32'hFFFFFF77, 1'b1, 32'h00000000, 3, 1'b0, 32'h00000077};
    vecs[15] = '{1'b0, 3'b001, 32'h113, 32'h0,        1'b0, 32'h0,        1, 1'b1, 32'h0};

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; addrmode = 3'b000;
    addr = '0; write_data = '0;
    repeat (3) tick();
    chk("reset_strobes", {28'd0, done, ram_we, rd_valid, err}, 32'd0);
    rst = 1'b0;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_ram_addr", ram_addr, 32'd0);
    chk("reset_data", ram_din | rd_data, 32'd0);
    $display("reset: ready=%0b ram_addr=%h", req_ready, ram_addr);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);

    // Reset during MERGE of a byte store: access is abandoned, RAM untouched
    preload(32'h120, 32'h11223344);
    req_valid = 1'b1; req_we = 1'b1; addrmode = 3'b000; addr = 32'h121; write_data = 32'h99;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstm_done", 32'(done), 32'd0);
    chk("rstm_we", 32'(ram_we), 32'd0);
    tick();
    rst = 1'b0;
    chk("rstm_ready", 32'(req_ready), 32'd1);
    chk("rstm_capture_cleared", ram_addr, 32'd0);
    q = 0;
    for (int c = 0; c < 5; c++) begin
      if (ram_we || done || rd_valid) q++;
      tick();
    end
    chk("rstm_quiet", 32'(q), 32'd0);
    chk("rstm_ram", mem[8'h48], 32'h11223344);
    $display("seq reset-in-merge store: ram=%h", mem[8'h48]);

    // Reset during MERGE of a load: no rd_valid, no done
    req_valid = 1'b1; req_we = 1'b0; addrmode = 3'b010; addr = 32'h120;
    tick();
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rstl_rdvalid", 32'(rd_valid), 32'd0);
    chk("rstl_done", 32'(done), 32'd0);
    tick();
    rst = 1'b0;
    chk("rstl_ready", 32'(req_ready), 32'd1);
    $display("seq reset-in-merge load: rd_valid=%0b", rd_valid);

    // Reset asserted in WRITE: the write must be suppressed
    preload(32'h130, 32'hDEAD0000);
    req_valid = 1'b1; req_we = 1'b1; addrmode = 3'b010; addr = 32'h130; write_data = 32'h12345678;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_we", 32'(ram_we), 32'd0);
    tick();
    rst = 1'b0;
    chk("rstw_ready", 32'(req_ready), 32'd1);
    chk("rstw_ram", mem[8'h4C], 32'hDEAD0000);
    $display("seq reset-in-write: ram=%h", mem[8'h4C]);

    // Two queued stores with req_valid held high; the byte store merges over
    // the word written just before it.
    req_valid = 1'b1; req_we = 1'b1; addrmode = 3'b010; addr = 32'h140; write_data = 32'hAAAA5555;
    chk("b2b_ready0", 32'(req_ready), 32'd1);
    tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_we1", 32'(ram_we), 32'd1);
    chk("b2b_din1", ram_din, 32'hAAAA5555);
    chk("b2b_busy1", 32'(req_ready), 32'd0);
    addrmode = 3'b000; addr = 32'h141; write_data = 32'h77;
    tick();
    chk("b2b_ready_after_done", 32'(req_ready), 32'd1);
    tick();
    chk("b2b_busy_read", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_busy_merge", 32'(req_ready), 32'd0);
    chk("b2b_no_early_done", 32'(done), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_we2", 32'(ram_we), 32'd1);
    chk("b2b_addr2", ram_addr, 32'h140);
    chk("b2b_din2", ram_din, 32'hAAAA7755);
    chk("b2b_busy_write", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_ram", mem[8'h50], 32'hAAAA7755);
    $display("seq back-to-back: ram=%h", mem[8'h50]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
